imm_extend_pipe: RTL and testbench
==================================

Name: imm_extend_pipe

Overview:
- Parametrised, buffered successor to the core's combinational immediate extender.
- Takes instruction bits [31:7] plus an immediate type and produces an XLEN-wide extended immediate, carried alongside a tag.
- Output passes through a DEPTH-entry FIFO with valid/ready handshakes on both sides, so decode can run decoupled from the execute stage.
- Adds RV64 widening, a zero-extended CSR immediate (ZTYPE), an illegal-type flag and a flush input.

Parameters:
- XLEN, 32, output immediate width; legal values 32 or 64.
- DEPTH, 2, output FIFO entries; power of two, 2..8.
- TAG_W, 5, width of the sideband tag carried with each immediate.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous; empties the FIFO.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_inst  in  25  instruction bits [31:7]; index 0 = instruction bit 7.
- in_imm_type  in  3  immediate type, Parameters.v codes: ITYPE, STYPE, BTYPE, UTYPE, JTYPE; ZTYPE is added to Parameters.v as the first unused 3-bit code.
- in_tag  in  TAG_W  sideband, returned unchanged.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts head.
- out_imm  out  XLEN  extended immediate.
- out_tag  out  TAG_W  tag of head.
- out_err  out  1  head had an unrecognised type.

Behaviour:
- Reset (rst_n low, asynchronous):
  - FIFO empty; read/write pointers and count cleared.
  - out_valid=0, out_imm=0, out_tag=0, out_err=0; in_ready=1 after reset release.
- Accept occurs when in_valid & in_ready at a clock edge; pop occurs when out_valid & out_ready.
- Extension is combinational on the input; the result is written to the FIFO. Latency from accept to out_valid is 1 cycle when empty.
- Extension rules, with s = inst[31] replicated:
  - ITYPE: s, inst[30:20].
  - STYPE: s, inst[30:25], inst[11:7].
  - BTYPE: s, inst[7], inst[30:25], inst[11:8], 0.
  - JTYPE: s, inst[19:12], inst[20], inst[30:21], 0.
  - UTYPE: inst[31:12], 12'b0; for XLEN=64, bits [63:32] replicate inst[31].
  - ZTYPE: zero-extended inst[19:15].
  - Every signed result is sign-extended to the full XLEN.
- Unused codes: imm=0 and err=1 stored with the entry. The beat is still accepted and popped normally.
- in_ready = (count != DEPTH). No combinational path from out_ready to in_ready.
- Full FIFO with simultaneous push and pop: in_ready is 0, so there is no push; the pop proceeds.
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged; both pointers advance.
- Pointers wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
- Outputs out_imm/out_tag/out_err always reflect the FIFO head. They hold stable while out_valid & !out_ready.
- flush:
  - Clears count and pointers at the edge; out_valid=0 next cycle.
  - A beat presented in the same cycle is dropped (flush wins).
  - A pop in the same cycle is irrelevant.
- Reset asserted mid-stream discards all entries immediately.

Optional Feature:
- IMM_EXTEND_BYPASS_EN.
- Defined:
  - When the FIFO is empty and in_valid=1, the head outputs are driven combinationally from the extender, with out_valid=in_valid.
  - If out_ready=1 in that cycle, the beat is consumed with zero latency and not written to the FIFO.
  - In bypass, in_ready remains the registered (count != DEPTH) value.
  - flush still suppresses out_valid in the bypass path.
- Undefined: no combinational in->out path; minimum latency is 1 cycle.

Test Plan:
- XLEN=32, ITYPE, inst word 0xFFF00093 (in_inst = word[31:7]), tag 3, out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_tag=3, out_err=0.
- BTYPE inst 0xFE000EE3 -> 0xFFFFFFFC. JTYPE inst 0x0010006F -> 0x00000800. ZTYPE inst with [19:15]=5'b11111 -> 0x0000001F.
- XLEN=64, UTYPE inst 0x800000B7 -> out_imm=0xFFFFFFFF80000000.
- DEPTH=2, out_ready=0, push 3 beats back-to-back -> in_ready drops after the 2nd accept, 3rd beat held. Then out_ready=1 -> beats pop in order; in_ready returns 1 cycle after the first pop.
- FIFO holding 2 entries, assert flush with in_valid=1 -> next cycle out_valid=0, count 0, flushed-cycle beat never appears.
- Unused type code, tag 7 -> out_imm=0, out_err=1, out_tag=7. The following ITYPE beat has out_err=0.
- Bypass build: empty FIFO, in_valid=1, out_ready=1, ITYPE 0xFFF00093 -> out_valid=1 and out_imm=0xFFFFFFFF in the same cycle, FIFO count stays 0.

Source files
------------

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: RISC-V immediate extender feeding a DEPTH-entry valid/ready output FIFO.
// Optional build macro IMM_EXTEND_BYPASS_EN adds a zero-latency path while the FIFO is empty.
module imm_extend_pipe #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [24:0]      in_inst,
    input  logic [2:0]       in_imm_type,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
);

    // Immediate type codes shared with the core decoder; code 0 (RTYPE) and 7 are unused here
    localparam logic [2:0] ITYPE = 3'd1;
    localparam logic [2:0] STYPE = 3'd2;
    localparam logic [2:0] BTYPE = 3'd3;
    localparam logic [2:0] UTYPE = 3'd4;
    localparam logic [2:0] JTYPE = 3'd5;
    localparam logic [2:0] ZTYPE = 3'd6;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    logic            sign_s;
    logic [XLEN-1:0] ext_imm_s;
    logic            ext_err_s;

    logic [XLEN-1:0]  imm_mem_r [DEPTH];
    logic [TAG_W-1:0] tag_mem_r [DEPTH];
    logic             err_mem_r [DEPTH];

    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;

    logic fifo_empty_s;
    logic accept_s;
    logic push_s;
    logic pop_s;

    assign sign_s = in_inst[24];

    // Extender: in_inst[k] carries instruction bit k+7, so inst[31] is in_inst[24]
    always_comb begin
        ext_imm_s = {XLEN{1'b0}};
        ext_err_s = 1'b0;
        case (in_imm_type)
            ITYPE: ext_imm_s = {{(XLEN-11){sign_s}}, in_inst[23:13]};
            STYPE: ext_imm_s = {{(XLEN-11){sign_s}}, in_inst[23:18], in_inst[4:0]};
            BTYPE: ext_imm_s = {{(XLEN-12){sign_s}}, in_inst[0], in_inst[23:18],
                                in_inst[4:1], 1'b0};
            JTYPE: ext_imm_s = {{(XLEN-20){sign_s}}, in_inst[12:5], in_inst[13],
                                in_inst[23:14], 1'b0};
            UTYPE: ext_imm_s = {{(XLEN-31){sign_s}}, in_inst[23:5], 12'b0};
            ZTYPE: ext_imm_s = {{(XLEN-5){1'b0}}, in_inst[12:8]};
            default: begin
                ext_imm_s = {XLEN{1'b0}};
                ext_err_s = 1'b1;
            end
        endcase
    end

    assign fifo_empty_s = (count_r == CNT_ZERO);
    // Ready depends only on the registered count, never on out_ready
    assign in_ready     = (count_r != FULL_CNT);
    assign accept_s     = in_valid & in_ready;
    assign pop_s        = ~fifo_empty_s & out_ready;

`ifdef IMM_EXTEND_BYPASS_EN
    logic bypass_s;
    logic bypass_take_s;

    assign bypass_s      = fifo_empty_s & in_valid;
    assign bypass_take_s = bypass_s & ~flush & out_ready;
    assign push_s        = accept_s & ~flush & ~bypass_take_s;

    assign out_valid = bypass_s ? (in_valid & ~flush) : ~fifo_empty_s;
    assign out_imm   = bypass_s ? ext_imm_s : imm_mem_r[rd_ptr_r];
    assign out_tag   = bypass_s ? in_tag    : tag_mem_r[rd_ptr_r];
    assign out_err   = bypass_s ? ext_err_s : err_mem_r[rd_ptr_r];
`else
    assign push_s    = accept_s & ~flush;

    assign out_valid = ~fifo_empty_s;
    assign out_imm   = imm_mem_r[rd_ptr_r];
    assign out_tag   = tag_mem_r[rd_ptr_r];
    assign out_err   = err_mem_r[rd_ptr_r];
`endif

    // Entry storage; cleared on reset so an empty FIFO presents all-zero head fields
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                imm_mem_r[i] <= {XLEN{1'b0}};
                tag_mem_r[i] <= {TAG_W{1'b0}};
                err_mem_r[i] <= 1'b0;
            end
        end else if (push_s) begin
            imm_mem_r[wr_ptr_r] <= ext_imm_s;
            tag_mem_r[wr_ptr_r] <= in_tag;
            err_mem_r[wr_ptr_r] <= ext_err_s;
        end else begin
            imm_mem_r[wr_ptr_r] <= imm_mem_r[wr_ptr_r];
        end
    end

    // Pointer and occupancy tracking; flush overrides any push or pop in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else if (flush) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Scoreboard bench for imm_extend_pipe: XLEN=32 and XLEN=64 instances share one stimulus stream.
module tb_imm_extend_pipe;

    localparam logic [2:0] RTYPE = 3'd0;
    localparam logic [2:0] ITYPE = 3'd1;
    localparam logic [2:0] STYPE = 3'd2;
    localparam logic [2:0] BTYPE = 3'd3;
    localparam logic [2:0] UTYPE = 3'd4;
    localparam logic [2:0] JTYPE = 3'd5;
    localparam logic [2:0] ZTYPE = 3'd6;
    localparam logic [2:0] BADTY = 3'd7;

    typedef struct packed {
        logic [63:0] imm;
        logic [4:0]  tag;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic [24:0] in_inst;
    logic [2:0]  in_imm_type;
    logic [4:0]  in_tag;

    logic        rdy32, ov32, err32;
    logic [31:0] imm32;
    logic [4:0]  tag32;
    logic        rdy64, ov64, err64;
    logic [63:0] imm64;
    logic [4:0]  tag64;

    exp_t q32[$];
    exp_t q64[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    imm_extend_pipe #(.XLEN(32), .DEPTH(2), .TAG_W(5)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy32), .in_inst(in_inst),
        .in_imm_type(in_imm_type), .in_tag(in_tag),
        .out_valid(ov32), .out_ready(out_ready), .out_imm(imm32),
        .out_tag(tag32), .out_err(err32)
    );

    imm_extend_pipe #(.XLEN(64), .DEPTH(2), .TAG_W(5)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy64), .in_inst(in_inst),
        .in_imm_type(in_imm_type), .in_tag(in_tag),
        .out_valid(ov64), .out_ready(out_ready), .out_imm(imm64),
        .out_tag(tag64), .out_err(err64)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic [31:0] w, input logic [2:0] ty, input logic [4:0] tg);
        in_inst     = w[31:7];
        in_imm_type = ty;
        in_tag      = tg;
    endtask

    task automatic expect_beat(input logic [63:0] ei, input logic [4:0] tg, input logic ee);
        exp_t e;
        e.imm = ei;
        e.tag = tg;
        e.err = ee;
        q32.push_back(e);
        q64.push_back(e);
    endtask

    // Present one beat, wait (bounded) for in_ready, record its expectation, hold through the accept edge
    task automatic send(input logic [31:0] w, input logic [2:0] ty, input logic [4:0] tg,
                        input logic [63:0] ei, input logic ee);
        int n;
        n = 0;
        set_beat(w, ty, tg);
        in_valid = 1'b1;
        while (!rdy32 && n < 100) begin
            step();
            n++;
        end
        if (!rdy32) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: got in_ready=0 after %0d cycles, expected 1", n);
        end else begin
            expect_beat(ei, tg, ee);
        end
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_inst = 25'd0; in_imm_type = 3'd0; in_tag = 5'd0;

        fork
            begin : monitor
                exp_t e;
                forever begin
                    @(negedge clk);
                    if (ov32 && out_ready) begin
                        if (q32.size() == 0) begin
                            n_cmp++; n_bad++;
                            $display("FAIL unexpected32: got imm %h tag %0d, expected no beat", imm32, tag32);
                        end else begin
                            e = q32.pop_front();
                            chk("imm32", {32'd0, imm32}, {32'd0, e.imm[31:0]});
                            chk("tag32", {59'd0, tag32}, {59'd0, e.tag});
                            chk("err32", {63'd0, err32}, {63'd0, e.err});
                        end
                    end
                    if (ov64 && out_ready) begin
                        if (q64.size() == 0) begin
                            n_cmp++; n_bad++;
                            $display("FAIL unexpected64: got imm %h tag %0d, expected no beat", imm64, tag64);
                        end else begin
                            e = q64.pop_front();
                            chk("imm64", imm64, e.imm);
                            chk("tag64", {59'd0, tag64}, {59'd0, e.tag});
                            chk("err64", {63'd0, err64}, {63'd0, e.err});
                        end
                    end
                end
            end
        join_none

        // Reset state
        #12;
        chk("rst_valid32", {63'd0, ov32}, 64'd0);
        chk("rst_imm32",   {32'd0, imm32}, 64'd0);
        chk("rst_tag32",   {59'd0, tag32}, 64'd0);
        chk("rst_err32",   {63'd0, err32}, 64'd0);
        chk("rst_valid64", {63'd0, ov64}, 64'd0);
        chk("rst_imm64",   imm64, 64'd0);
        rst_n = 1'b1;
        step();
        chk("rst_ready32", {63'd0, rdy32}, 64'd1);
        chk("rst_ready64", {63'd0, rdy64}, 64'd1);

        // First beat into an empty FIFO: latency check
        out_ready = 1'b1;
        set_beat(32'hFFF00093, ITYPE, 5'd3);
        in_valid = 1'b1;
        #1;
`ifdef IMM_EXTEND_BYPASS_EN
        chk("byp_valid", {63'd0, ov32}, 64'd1);
        chk("byp_imm",   {32'd0, imm32}, 64'h0000_0000_FFFF_FFFF);
`else
        chk("lat_pre_valid", {63'd0, ov32}, 64'd0);
`endif
        expect_beat(64'hFFFF_FFFF_FFFF_FFFF, 5'd3, 1'b0);
        step();
        in_valid = 1'b0;
`ifdef IMM_EXTEND_BYPASS_EN
        chk("byp_no_store", {63'd0, ov32}, 64'd0);
`else
        chk("lat_post_valid", {63'd0, ov32}, 64'd1);
`endif
        step();

        // Streaming directed vectors
        send(32'hFE000EE3, BTYPE, 5'd4, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        send(32'h0010006F, JTYPE, 5'd5, 64'h0000_0000_0000_0800, 1'b0);
        send(32'h800F8073, ZTYPE, 5'd6, 64'h0000_0000_0000_001F, 1'b0);
        send(32'h800000B7, UTYPE, 5'd1, 64'hFFFF_FFFF_8000_0000, 1'b0);
        send(32'hFE112E23, STYPE, 5'd2, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        send(32'h00A12423, STYPE, 5'd13, 64'h0000_0000_0000_0008, 1'b0);
        send(32'h7FF00093, ITYPE, 5'd14, 64'h0000_0000_0000_07FF, 1'b0);
        send(32'h00000033, BADTY, 5'd7, 64'd0, 1'b1);
        send(32'h00000033, RTYPE, 5'd11, 64'd0, 1'b1);
        send(32'h00500093, ITYPE, 5'd12, 64'h0000_0000_0000_0005, 1'b0);
        repeat (3) step();

        // Backpressure: fill two entries, third beat must wait
        out_ready = 1'b0;
        send(32'h00500093, ITYPE, 5'd8, 64'h5, 1'b0);
        send(32'h00A12423, STYPE, 5'd9, 64'h8, 1'b0);
        chk("full_ready32", {63'd0, rdy32}, 64'd0);
        chk("full_ready64", {63'd0, rdy64}, 64'd0);
        set_beat(32'h7FF00093, ITYPE, 5'd10);
        in_valid = 1'b1;
        step();
        step();
        chk("held_ready", {63'd0, rdy32}, 64'd0);
        chk("held_valid", {63'd0, ov32}, 64'd1);
        chk("held_head",  {32'd0, imm32}, 64'd5);
        out_ready = 1'b1;
        #1;
        chk("no_comb_ready", {63'd0, rdy32}, 64'd0);
        step();
        chk("ready_after_pop", {63'd0, rdy32}, 64'd1);
        expect_beat(64'h7FF, 5'd10, 1'b0);
        step();
        in_valid = 1'b0;
        repeat (4) step();

        // Flush with two entries queued and a beat on the input
        out_ready = 1'b0;
        send(32'h00500093, ITYPE, 5'd15, 64'h5, 1'b0);
        send(32'h0010006F, JTYPE, 5'd16, 64'h800, 1'b0);
        set_beat(32'hFFF00093, ITYPE, 5'd17);
        in_valid = 1'b1;
        flush    = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        q32.delete();
        q64.delete();
        chk("flush_valid32", {63'd0, ov32}, 64'd0);
        chk("flush_valid64", {63'd0, ov64}, 64'd0);
        chk("flush_ready",   {63'd0, rdy32}, 64'd1);
        out_ready = 1'b1;
        repeat (4) step();

        // Asynchronous reset mid-stream drops entries immediately
        out_ready = 1'b0;
        send(32'h00500093, ITYPE, 5'd18, 64'h5, 1'b0);
        send(32'h00500093, ITYPE, 5'd19, 64'h5, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        q32.delete();
        q64.delete();
        chk("arst_valid", {63'd0, ov32}, 64'd0);
        chk("arst_ready", {63'd0, rdy32}, 64'd1);
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        send(32'hFE000EE3, BTYPE, 5'd20, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        repeat (4) step();

        chk("q32_drained", 64'(q32.size()), 64'd0);
        chk("q64_drained", 64'(q64.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
